sys_array_result_drain: RTL and testbench
=========================================

// Module: sys_array_result_drain
//
// PURPOSE
//   Downstream stage of sys_array_fetcher. When the fetcher's ready rises, the
//   block captures the full result matrix (ARRAY_W_W x ARRAY_A_L elements,
//   each 2*DATA_WIDTH bits) into a shadow buffer. It then streams the elements
//   out one per beat, in row-major order, over a valid/ready handshake. This
//   releases the fetcher for the next computation while results drain.
//
// PARAMETERS
//   DATA_WIDTH  8  operand width; result element width is 2*DATA_WIDTH
//   ARRAY_W_W   5  result rows (rows of weight matrix)
//   ARRAY_A_L   5  result columns (columns of data matrix)
//
// PORTS
//   clk            in   1                       clock, rising edge
//   reset_n        in   1                       asynchronous, active-low reset
//   fetch_ready    in   1                       fetcher ready (level; result valid while high)
//   fetch_data     in   [0:W_W-1][0:A_L-1][2*DW-1:0]  fetcher out_data
//   out_valid      out  1                       element on out_data valid
//   out_ready      in   1                       consumer accepts element
//   out_data       out  2*DATA_WIDTH            result element
//   out_row        out  RW=max(1,$clog2(W_W))   row index of element
//   out_col        out  CW=max(1,$clog2(A_L))   column index of element
//   out_eol        out  1                       element is last of its row
//   out_last       out  1                       element is last of matrix
//   busy           out  1                       buffer holds undrained result
//   overrun        out  1                       sticky: a result was dropped
//   clear_overrun  in   1                       synchronous clear of overrun
//
// BEHAVIOUR
//   - Reset (async assert): all outputs 0, state IDLE, row/col counters 0.
//     fetch_ready history register resets to 1, so a level already high at
//     reset release is not a rising edge. Buffer contents are don't-care.
//   - Rise = fetch_ready high at this edge and low at previous edge. At most
//     one capture per rise; a held-high level never re-captures.
//   - States: IDLE, STREAM.
//     IDLE --rise--> capture fetch_data, row=col=0, STREAM. out_valid goes high
//       on the capture edge, so element [0][0] is visible the next cycle.
//     STREAM: a beat transfers when out_valid && out_ready. A transfer advances
//       col. col wraps at A_L-1 to 0 and increments row.
//     STREAM --transfer of [W_W-1][A_L-1]--> IDLE. out_valid and busy drop on
//       that edge.
//   - Handshake: while out_valid && !out_ready, out_data/row/col/eol/last are
//     held stable. out_valid never drops without a transfer, except on reset.
//   - out_data = buffer[row][col]. out_eol = (col==A_L-1).
//     out_last = out_eol && (row==W_W-1). busy = (state==STREAM).
//   - Rise coinciding with the final transfer: the new result is captured and
//     state stays STREAM. The next beat is new [0][0] with no bubble and no
//     overrun.
//   - Rise in STREAM at any other time: the new result is dropped, overrun set
//     to 1, and the current stream is unaffected.
//   - overrun stays 1 until clear_overrun. If a set and a clear occur in the
//     same cycle, set wins.
//   - Degenerate sizes (W_W=1 or A_L=1) work. With W_W=A_L=1 every beat has
//     out_eol=out_last=1.
//   - Reset mid-stream: immediate abort. The partial matrix is discarded and no
//     out_last is emitted.
//
// STRUCTURE
//   - Package sys_array_pkg: drain_state_t enum {IDLE,STREAM}; function
//     idx_w(n) returning max(1,$clog2(n)); result element typedef
//     logic [2*DATA_WIDTH-1:0].
//   - Sub-module sys_array_drain_ctr: row/col counter with advance and clear
//     inputs, wrap logic, eol/last flags, parameterised by row/col counts.
//   - Top: rise detector, FSM, shadow buffer register array, output mux,
//     overrun flag.
//
// TESTING  (DATA_WIDTH=8, W_W=5, A_L=5; fetch_data[r][c] = 16'h0100*r + c)
//   1 Reset with fetch_ready=1 throughout -> all outputs 0; after release, no
//     capture and busy stays 0.
//   2 Rise with out_ready=1 -> 25 consecutive beats, first beat one cycle after
//     the capture edge. Values 0000..0404 in row-major order. out_eol on cols
//     4; out_last only on beat 25; busy drops on that edge.
//   3 Random out_ready backpressure -> outputs stable while stalled, all 25
//     values in order, no duplicates.
//   4 Second rise at beat 10 -> overrun=1, remaining beats still from the first
//     matrix. Pulse clear_overrun -> overrun=0. clear_overrun together with a
//     new drop -> overrun stays 1.
//   5 Rise aligned with transfer of beat 25, new data = +16'h1000 -> next beat
//     1000, no idle cycle, overrun=0.
//   6 Assert reset_n=0 after beat 7 -> out_valid=0 immediately. After release,
//     a fresh rise streams from [0][0].

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array result drain path.
package sys_array_pkg;

  typedef enum logic {IDLE, STREAM} drain_state_t;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  typedef logic [2*DATA_WIDTH_DEF-1:0] result_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_array_drain_ctr.sv
// Row-major row/column walker with end-of-row and end-of-matrix flags.
module sys_array_drain_ctr
  import sys_array_pkg::*;
#(
  parameter int unsigned ROWS = 5,
  parameter int unsigned COLS = 5,
  parameter int unsigned RW   = idx_w(ROWS),
  parameter int unsigned CW   = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          advance,
  input  logic          clear,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          eol,
  output logic          last
);

  assign eol  = (col == CW'(COLS - 1));
  assign last = eol && (row == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (eol) begin
        col <= '0;
        row <= last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sys_array_result_drain.sv
// Captures the fetcher's result matrix on a ready rise and streams it out
// one element per valid/ready beat in row-major order.
module sys_array_result_drain
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W_W  = 5,
  parameter int unsigned ARRAY_A_L  = 5,
  parameter int unsigned RW         = idx_w(ARRAY_W_W),
  parameter int unsigned CW         = idx_w(ARRAY_A_L)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fetch_ready,
  input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] fetch_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic [RW-1:0]           out_row,
  output logic [CW-1:0]           out_col,
  output logic                    out_eol,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clear_overrun
);

  drain_state_t state, state_next;
  logic fetch_q;
  logic rise, xfer, final_xfer, capture, drop;
  logic eol, last;
  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] mat;

  // History resets high so a level already asserted at release is not a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_q <= 1'b1;
    else          fetch_q <= fetch_ready;
  end

  assign rise       = fetch_ready && !fetch_q;
  assign xfer       = (state == STREAM) && out_ready;
  assign final_xfer = xfer && last;
  assign capture    = rise && ((state == IDLE) || final_xfer);
  assign drop       = rise && (state == STREAM) && !final_xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = STREAM;
      STREAM:  if (final_xfer && !capture) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (capture) mat <= fetch_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (clear_overrun) overrun <= 1'b0;
  end

  sys_array_drain_ctr #(
    .ROWS (ARRAY_W_W),
    .COLS (ARRAY_A_L),
    .RW   (RW),
    .CW   (CW)
  ) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (xfer),
    .clear   (capture),
    .row     (out_row),
    .col     (out_col),
    .eol     (eol),
    .last    (last)
  );

  // Data and flags are gated so the outputs read zero whenever nothing is offered.
  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);
  assign out_data  = out_valid ? mat[out_row][out_col] : '0;
  assign out_eol   = out_valid && eol;
  assign out_last  = out_valid && last;

endmodule

// File: tb/tb_sys_array_result_drain.sv
// Randomized and directed bench for sys_array_result_drain against a queue model.
module tb_sys_array_result_drain;

  localparam int unsigned DW = 8;
  localparam int unsigned WW = 5;
  localparam int unsigned AL = 5;

  logic clk = 1'b0;
  logic reset_n;
  logic fetch_ready;
  logic [0:WW-1][0:AL-1][2*DW-1:0] fetch_data;
  logic out_valid, out_ready, out_eol, out_last, busy, overrun, clear_overrun;
  logic [2*DW-1:0] out_data;
  logic [2:0] out_row, out_col;

  sys_array_result_drain #(
    .DATA_WIDTH (DW),
    .ARRAY_W_W  (WW),
    .ARRAY_A_L  (AL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_ready   (fetch_ready),
    .fetch_data    (fetch_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_row       (out_row),
    .out_col       (out_col),
    .out_eol       (out_eol),
    .out_last      (out_last),
    .busy          (busy),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          r;
    int          c;
  } beat_t;

  beat_t q[$];
  logic  m_ovr;
  logic  m_prev;
  int    checks = 0;
  int    failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_matrix(input logic [15:0] base);
    for (int r = 0; r < WW; r++)
      for (int c = 0; c < AL; c++)
        fetch_data[r][c] = base + 16'(16'h0100 * r) + 16'(c);
  endtask

  task automatic check_outputs();
    check_eq("valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    check_eq("busy", {31'd0, busy}, {31'd0, q.size() != 0});
    check_eq("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (q.size() != 0) begin
      check_eq("data", {16'd0, out_data}, {16'd0, q[0].d});
      check_eq("row", {29'd0, out_row}, 32'(q[0].r));
      check_eq("col", {29'd0, out_col}, 32'(q[0].c));
      check_eq("eol", {31'd0, out_eol}, {31'd0, q[0].c == AL - 1});
      check_eq("last", {31'd0, out_last}, {31'd0, (q[0].c == AL - 1) && (q[0].r == WW - 1)});
    end else begin
      check_eq("idle_data", {16'd0, out_data}, 32'd0);
      check_eq("idle_last", {31'd0, out_last}, 32'd0);
    end
  endtask

  // One clock: drive inputs, advance the model by the stream rules, then check.
  task automatic step(input logic fr, input logic ordy, input logic clr, input logic [15:0] base);
    logic xfer, rise, drop;
    fetch_ready   = fr;
    out_ready     = ordy;
    clear_overrun = clr;
    set_matrix(base);
    xfer = (q.size() != 0) && ordy;
    rise = fr && !m_prev;
    if (xfer) void'(q.pop_front());
    drop = rise && (q.size() != 0);
    if (rise && !drop)
      for (int r = 0; r < WW; r++)
        for (int c = 0; c < AL; c++)
          q.push_back('{d: fetch_data[r][c], r: r, c: c});
    if (drop)     m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_prev = fr;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_prev = 1'b1;
  endtask

  task automatic drain(input logic random_ready);
    for (int i = 0; i < 400 && q.size() != 0; i++)
      step(1'b0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 16'h0);
    check_eq("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    // Reset with fetch_ready held high: no capture after release.
    reset_n = 1'b0;
    fetch_ready = 1'b1;
    out_ready = 1'b1;
    clear_overrun = 1'b0;
    set_matrix(16'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    repeat (4) step(1'b1, 1'b1, 1'b0, 16'h0);

    // Full-rate stream.
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check_eq("first_beat_visible", {31'd0, out_valid}, 32'd1);
    drain(1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0);

    // Random backpressure.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    drain(1'b1);

    // Drop at beat 10, clear, then clear coinciding with a new drop.
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    while (q.size() > 15) step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h2000);
    step(1'b1, 1'b1, 1'b0, 16'h2000);
    check_eq("overrun_set", {31'd0, overrun}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 16'h0);
    check_eq("overrun_cleared", {31'd0, overrun}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h3000);
    check_eq("set_wins", {31'd0, overrun}, 32'd1);
    while (q.size() > 1) step(1'b0, 1'b1, 1'b1, 16'h0);

    // Rise aligned with the final transfer: back-to-back matrices.
    step(1'b1, 1'b1, 1'b0, 16'h1000);
    check_eq("b2b_data", {16'd0, out_data}, 32'h1000);
    check_eq("b2b_overrun", {31'd0, overrun}, 32'd0);
    drain(1'b1);

    // Reset after beat 7 aborts immediately.
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    while (q.size() > 18) step(1'b1, 1'b1, 1'b0, 16'h0);
    fetch_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("reset_abort_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_abort_last", {31'd0, out_last}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0400);
    check_eq("fresh_first", {16'd0, out_data}, 32'h0400);
    drain(1'b1);

    // Random soak.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0), 16'($urandom_range(0, 16'hF000)));
    step(1'b0, 1'b1, 1'b0, 16'h0);
    drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
